alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit RV32I integer ALU plus branch comparator for the multi-cycle microcoded CPU core.
- The operation select is the instruction funct3 extended by one "alt" bit (instruction bit 30 for SUB/SRA).
- result and cmp are combinational, because the core consumes them in the same cycle.
- Registered copies are also provided for debug and pipelined users.

Parameters:
- WIDTH, 32, datapath width. Shift amount uses the low log2(WIDTH) bits of b.

Ports:
- clk  in  1  system clock
- rts_n  in  1  asynchronous active-low reset
- op  in  4  {alt, funct3}
- a  in  WIDTH  operand A (rs1)
- b  in  WIDTH  operand B (rs2 or sign-extended immediate, selected by the caller)
- result  out  WIDTH  combinational ALU result
- cmp  out  1  combinational branch-condition flag
- result_q  out  WIDTH  result registered on clk
- cmp_q  out  1  cmp registered on clk

Behaviour:
- result is combinational on op[2:0], with alt = op[3]:
  - 000: alt=0 gives a+b; alt=1 gives a-b. Both are modulo 2^32 with no carry out.
  - 001: SLL, a << b[4:0].
  - 010: SLT, 1 if $signed(a) < $signed(b), else 0 (zero-extended).
  - 011: SLTU, 1 if a < b unsigned, else 0.
  - 100: XOR, a ^ b.
  - 101: alt=0 gives SRL (logical, zero fill); alt=1 gives SRA (arithmetic, sign fill). Shift amount is b[4:0].
  - 110: OR, a | b.
  - 111: AND, a & b.
- alt is ignored for every funct3 except 000 and 101.
- b[31:5] is ignored for all shifts.
- cmp is combinational on op[2:0] only; alt is ignored, because the branch immediate may drive bit 30:
  - 000: a==b
  - 001: a!=b
  - 010: signed a<b
  - 011: unsigned a<b
  - 100: signed a<b (BLT)
  - 101: signed a>=b (BGE)
  - 110: unsigned a<b (BLTU)
  - 111: unsigned a>=b (BGEU)
- No X propagation on a defined op; all 16 op codes produce a defined output.
- Registered outputs:
  - result_q and cmp_q load result and cmp on every posedge clk. One-cycle latency, no enable.
  - Reset: rts_n low clears result_q=0 and cmp_q=0 asynchronously, including mid-operation. The first load happens on the first posedge after rts_n rises.
  - The combinational outputs are unaffected by reset.
- Boundary cases:
  - Shift by 0 returns a unchanged.
  - SRA of 0x80000000 by 31 gives 0xFFFFFFFF.
  - 0x7FFFFFFF+1 wraps to 0x80000000.
  - 0-1 gives 0xFFFFFFFF.
  - SLT(0x80000000, 0) gives 1.
  - SLTU(0x80000000, 0) gives 0.

Decomposition:
- Shared package: an op enum holding ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND as 4-bit {alt, funct3} constants.
- Also in the package: branch funct3 constants BEQ, BNE, BLT, BGE, BLTU, BGEU, and the WIDTH default.
- One natural sub-module: alu_cmp, which computes eq, signed lt and unsigned lt once.
  - alu uses its lt outputs for SLT/SLTU.
  - alu selects cmp from eq and lt according to funct3.
- The shifter and adder stay inline.

Test Plan:
- Add/sub:
  - op=0000, a=0x7FFFFFFF, b=1 -> result=0x80000000.
  - op=1000, a=0, b=1 -> result=0xFFFFFFFF.
  - op=0000, a=5, b=0xFFFFFFFD -> result=2.
- Shifts:
  - op=0101, a=0x80000000, b=0x21 -> result=0x40000000 (only b[4:0]=1 used).
  - op=1101, same operands -> result=0xC0000000.
  - op=0001, a=1, b=31 -> result=0x80000000.
- Compare/set:
  - op=0010, a=0x80000000, b=0 -> result=1.
  - op=0011, same operands -> result=0.
  - op=0100, a=0xF0F0F0F0, b=0xFF00FF00 -> result=0x0FF00FF0.
  - op=0110, same operands -> 0xFFF0FFF0.
  - op=0111, same operands -> 0xF000F000.
- Branch flag:
  - a=b=3: op=0000 -> cmp=1; op=0001 -> cmp=0.
  - a=0xFFFFFFFF, b=1: op=0100 -> cmp=1; op=0110 -> cmp=0; op=1101 -> cmp=0; op=0111 -> cmp=1. Confirms alt is ignored for cmp.
- Registers/reset:
  - Drive op=0000, a=2, b=3 and clock once -> result_q=5, cmp_q=0.
  - Assert rts_n=0 between clock edges -> result_q=0, cmp_q=0 immediately; result stays 5.
  - Release rts_n -> next posedge reloads result_q=5.
- Random: 10k random op/a/b vectors checked against a reference model, for both combinational and registered outputs.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU: {alt, funct3} op codes, branch funct3 codes
// and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b1000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b1101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111
  } alu_op_e;

  // funct3 fields of the ALU ops, used when alt does not matter
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

endpackage

// File: rtl/alu_cmp.sv
// Operand comparator shared by the set-less-than ops and the branch flag.
module alu_cmp
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt_s,
  output logic             lt_u
);

  assign eq   = (a == b);
  assign lt_u = (a < b);
  assign lt_s = ($signed(a) < $signed(b));

endmodule

// File: rtl/alu.sv
// RV32I integer ALU and branch comparator with combinational outputs and
// one-cycle registered copies.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rts_n,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cmp,
  output logic [WIDTH-1:0] result_q,
  output logic             cmp_q
);

  localparam int SHW = $clog2(WIDTH);

  logic             eq;
  logic             lt_s;
  logic             lt_u;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] shr;

  alu_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a    (a),
    .b    (b),
    .eq   (eq),
    .lt_s (lt_s),
    .lt_u (lt_u)
  );

  assign shamt = b[SHW-1:0];
  assign sum   = (op == OP_SUB) ? (a - b) : (a + b);
  assign shr   = (op == OP_SRA) ? WIDTH'($signed(a) >>> shamt) : (a >> shamt);

  always_comb begin
    result = '0;
    case (op[2:0])
      F3_ADDSUB: result = sum;
      F3_SLL:    result = a << shamt;
      F3_SLT:    result = {{(WIDTH-1){1'b0}}, lt_s};
      F3_SLTU:   result = {{(WIDTH-1){1'b0}}, lt_u};
      F3_XOR:    result = a ^ b;
      F3_SR:     result = shr;
      F3_OR:     result = a | b;
      F3_AND:    result = a & b;
      default:   result = '0;
    endcase
  end

  // alt is deliberately ignored here: on branches bit 30 belongs to the immediate
  always_comb begin
    cmp = 1'b0;
    case (op[2:0])
      BEQ:     cmp = eq;
      BNE:     cmp = ~eq;
      3'b010:  cmp = lt_s;
      3'b011:  cmp = lt_u;
      BLT:     cmp = lt_s;
      BGE:     cmp = ~lt_s;
      BLTU:    cmp = lt_u;
      BGEU:    cmp = ~lt_u;
      default: cmp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) begin
      result_q <= '0;
      cmp_q    <= 1'b0;
    end else begin
      result_q <= result;
      cmp_q    <= cmp;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset sequence and random
// vectors, with a scoreboard queue for the registered outputs.
module tb_alu;

  logic        clk;
  logic        rts_n;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        cmp;
  logic [31:0] result_q;
  logic        cmp_q;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_result;
    logic        exp_cmp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        cmp;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  alu #(.WIDTH(32)) dut (
    .clk      (clk),
    .rts_n    (rts_n),
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .cmp      (cmp),
    .result_q (result_q),
    .cmp_q    (cmp_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (op=%b a=0x%08h b=0x%08h)",
               name, actual, expected, op, a, b);
    end
  endtask

  // Independent reference model written at the bit level
  function automatic logic [31:0] model_result(input logic [3:0] m_op,
                                               input logic [31:0] ma,
                                               input logic [31:0] mb);
    logic [4:0]  sh;
    logic [31:0] fill;
    sh   = mb[4:0];
    fill = ma[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (m_op[2:0])
      3'd0: return m_op[3] ? ma + (~mb + 32'd1) : ma + mb;
      3'd1: return ma << sh;
      3'd2: return {31'd0, ((ma ^ 32'h8000_0000) < (mb ^ 32'h8000_0000))};
      3'd3: return {31'd0, (ma < mb)};
      3'd4: return ma ^ mb;
      3'd5: return m_op[3] ? ((ma >> sh) | fill) : (ma >> sh);
      3'd6: return ma | mb;
      default: return ma & mb;
    endcase
  endfunction

  function automatic logic model_cmp(input logic [3:0] m_op,
                                     input logic [31:0] ma,
                                     input logic [31:0] mb);
    logic slt;
    logic ult;
    slt = (ma ^ 32'h8000_0000) < (mb ^ 32'h8000_0000);
    ult = ma < mb;
    case (m_op[2:0])
      3'd0: return ma == mb;
      3'd1: return ma != mb;
      3'd2: return slt;
      3'd3: return ult;
      3'd4: return slt;
      3'd5: return !slt;
      3'd6: return ult;
      default: return !ult;
    endcase
  endfunction

  // Drive one vector, check combinational outputs, then the registered copy a cycle later
  task automatic apply_stimulus(input logic [3:0] v_op, input logic [31:0] va,
                                input logic [31:0] vb, input logic [31:0] exp_res,
                                input logic exp_cmp, input string tag);
    exp_t e;
    op = v_op;
    a  = va;
    b  = vb;
    #1;
    check_output({tag, ".result"}, result, exp_res);
    check_output({tag, ".cmp"}, {31'd0, cmp}, {31'd0, exp_cmp});
    e.res = exp_res;
    e.cmp = exp_cmp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s.scoreboard: got empty queue, expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check_output({tag, ".result_q"}, result_q, e.res);
      check_output({tag, ".cmp_q"}, {31'd0, cmp_q}, {31'd0, e.cmp});
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v_op, input logic [31:0] va,
                              input logic [31:0] vb, input logic [31:0] r,
                              input logic c);
    vec_t v;
    v.op = v_op; v.a = va; v.b = vb; v.exp_result = r; v.exp_cmp = c;
    return v;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;

    rts_n = 1'b0;
    op = 4'b0000;
    a  = 32'h0;
    b  = 32'h0;

    vecs.push_back(mk(4'b0000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0));
    vecs.push_back(mk(4'b1000, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(4'b0000, 32'h5,         32'hFFFF_FFFD, 32'h2,         1'b0));
    vecs.push_back(mk(4'b0101, 32'h8000_0000, 32'h21,        32'h4000_0000, 1'b0));
    vecs.push_back(mk(4'b1101, 32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0));
    vecs.push_back(mk(4'b0001, 32'h1,         32'd31,        32'h8000_0000, 1'b1));
    vecs.push_back(mk(4'b0010, 32'h8000_0000, 32'h0,         32'h1,         1'b1));
    vecs.push_back(mk(4'b0011, 32'h8000_0000, 32'h0,         32'h0,         1'b0));
    vecs.push_back(mk(4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1));
    vecs.push_back(mk(4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b1));
    vecs.push_back(mk(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0));
    vecs.push_back(mk(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1));
    vecs.push_back(mk(4'b0001, 32'h1234_5678, 32'h0,         32'h1234_5678, 1'b1));
    vecs.push_back(mk(4'b1101, 32'h8765_4321, 32'h20,        32'h8765_4321, 1'b0));
    vecs.push_back(mk(4'b1101, 32'h8000_0000, 32'h1F,        32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(4'b0101, 32'h8000_0000, 32'h1F,        32'h1,         1'b0));
    vecs.push_back(mk(4'b0000, 32'h3,         32'h3,         32'h6,         1'b1));
    vecs.push_back(mk(4'b0001, 32'h3,         32'h3,         32'h18,        1'b0));
    vecs.push_back(mk(4'b0100, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFE, 1'b1));
    vecs.push_back(mk(4'b0110, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(4'b1101, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b1));
    vecs.push_back(mk(4'b1010, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b1));

    // Reset state while rts_n is held low across clock edges
    repeat (2) @(posedge clk);
    #1;
    check_output("reset.result_q", result_q, 32'h0);
    check_output("reset.cmp_q", {31'd0, cmp_q}, 32'h0);
    @(negedge clk);
    rts_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_result,
                     vecs[i].exp_cmp, $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a cycle, then reload after release
    apply_stimulus(4'b0000, 32'h2, 32'h3, 32'h5, 1'b0, "pre_reset");
    #2;
    rts_n = 1'b0;
    #1;
    check_output("async_reset.result_q", result_q, 32'h0);
    check_output("async_reset.cmp_q", {31'd0, cmp_q}, 32'h0);
    check_output("async_reset.result", result, 32'h5);
    @(negedge clk);
    check_output("held_reset.result_q", result_q, 32'h0);
    rts_n = 1'b1;
    #1;
    check_output("released.result_q", result_q, 32'h0);
    @(posedge clk);
    #1;
    check_output("reload.result_q", result_q, 32'h5);
    check_output("reload.cmp_q", {31'd0, cmp_q}, 32'h0);

    for (int n = 0; n < 10000; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = rand_operand();
      rb  = rand_operand();
      apply_stimulus(rop, ra, rb, model_result(rop, ra, rb), model_cmp(rop, ra, rb),
                     "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
